// File: rtl/mem_access_stage.sv
//------------------------------------------------------------------------------
// mem_access_stage : MEM-stage controller; turns sub-word loads/stores into
//                    word accesses (RMW for byte/half stores) and fills MEM/WB.
// Optional feature macro: MISALIGN_TRAP_EN
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_access_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [WIDTH-1:0]  ex_addr,
    input  logic [WIDTH-1:0]  ex_wdata,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memtoreg,
    output logic              dmem_memwrite,
    output logic [WIDTH-1:0]  dmem_addr,
    output logic [WIDTH-1:0]  dmem_writedata,
    input  logic [WIDTH-1:0]  dmem_readdata,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [REG_AW-1:0] wb_rd,
    output logic [WIDTH-1:0]  wb_rdata,
    output logic [WIDTH-1:0]  wb_alu
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              wb_misalign
`endif
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RMW  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   merge_q, merge_d;
    logic               wb_valid_q, wb_valid_d;
    logic               wb_regwrite_q, wb_regwrite_d;
    logic               wb_memtoreg_q, wb_memtoreg_d;
    logic [REG_AW-1:0]  wb_rd_q, wb_rd_d;
    logic [WIDTH-1:0]   wb_rdata_q, wb_rdata_d;
    logic [WIDTH-1:0]   wb_alu_q, wb_alu_d;
`ifdef MISALIGN_TRAP_EN
    logic               wb_misalign_q, wb_misalign_d;
`endif

    logic               is_store, is_load, is_sub, mis_access;
    logic [4:0]         byte_shift, half_shift;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [WIDTH-1:0]   load_ext, merged;
    logic               stall_c, memwrite_c;
    logic [WIDTH-1:0]   writedata_c;

    // Lane decode, load extension and store merge
    always_comb begin
        is_store   = ex_valid & ex_memwrite;
        is_load    = ex_valid & ex_memread & ~ex_memwrite;
        is_sub     = ~ex_size[1];
`ifdef MISALIGN_TRAP_EN
        mis_access = (is_store | is_load) &
                     (((ex_size == 2'b01) & ex_addr[0]) | (ex_size[1] & (|ex_addr[1:0])));
`else
        mis_access = 1'b0;
`endif
        byte_shift = {ex_addr[1:0], 3'b000};
        half_shift = {ex_addr[1], 4'b0000};
        ld_byte    = dmem_readdata[byte_shift +: 8];
        ld_half    = dmem_readdata[half_shift +: 16];
        case (ex_size)
            2'b00:   load_ext = {{(WIDTH-8){~ex_unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = {{(WIDTH-16){~ex_unsigned & ld_half[15]}}, ld_half};
            default: load_ext = dmem_readdata;
        endcase
        merged = dmem_readdata;
        if (ex_size == 2'b00) begin
            merged[byte_shift +: 8] = ex_wdata[7:0];
        end else begin
            merged[half_shift +: 16] = ex_wdata[15:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        merge_d       = merge_q;
        stall_c       = 1'b0;
        memwrite_c    = 1'b0;
        writedata_c   = ex_wdata;
        wb_valid_d    = ex_valid;
        wb_regwrite_d = ex_valid & ex_regwrite & ~mis_access;
        wb_memtoreg_d = ex_memtoreg;
        wb_rd_d       = ex_rd;
        wb_alu_d      = ex_addr;
        wb_rdata_d    = is_load ? load_ext : '0;
`ifdef MISALIGN_TRAP_EN
        wb_misalign_d = mis_access;
`endif
        case (state_q)
            S_IDLE: begin
                if (is_store && !mis_access) begin
                    if (is_sub) begin
                        // Read phase: capture merged word, insert a bubble into MEM/WB
                        stall_c       = 1'b1;
                        merge_d       = merged;
                        state_d       = S_RMW;
                        wb_valid_d    = 1'b0;
                        wb_regwrite_d = 1'b0;
                        wb_memtoreg_d = 1'b0;
                        wb_rd_d       = '0;
                        wb_alu_d      = '0;
                        wb_rdata_d    = '0;
                    end else begin
                        memwrite_c = 1'b1;
                    end
                end
            end
            S_RMW: begin
                memwrite_c    = 1'b1;
                writedata_c   = merge_q;
                wb_regwrite_d = 1'b0;
                wb_rdata_d    = '0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            merge_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_rdata_q    <= '0;
            wb_alu_q      <= '0;
`ifdef MISALIGN_TRAP_EN
            wb_misalign_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            merge_q       <= merge_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_rd_q       <= wb_rd_d;
            wb_rdata_q    <= wb_rdata_d;
            wb_alu_q      <= wb_alu_d;
`ifdef MISALIGN_TRAP_EN
            wb_misalign_q <= wb_misalign_d;
`endif
        end
    end

    // Reset abandons an in-flight RMW write
    assign dmem_memwrite  = memwrite_c & ~reset;
    assign dmem_addr      = ex_addr;
    assign dmem_writedata = writedata_c;
    assign mem_stall      = stall_c;
    assign wb_valid       = wb_valid_q;
    assign wb_regwrite    = wb_regwrite_q;
    assign wb_memtoreg    = wb_memtoreg_q;
    assign wb_rd          = wb_rd_q;
    assign wb_rdata       = wb_rdata_q;
    assign wb_alu         = wb_alu_q;
`ifdef MISALIGN_TRAP_EN
    assign wb_misalign    = wb_misalign_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
//------------------------------------------------------------------------------
// tb_mem_access_stage : directed bench with a byte-addressed reference memory
//                       and an in-order queue of expected MEM/WB entries.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_clr;
    logic        ex_valid, ex_memread, ex_memwrite, ex_unsigned, ex_regwrite, ex_memtoreg;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        dmem_memwrite, mem_stall;
    logic [31:0] dmem_addr, dmem_writedata, dmem_readdata;
    logic        wb_valid, wb_regwrite, wb_memtoreg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rdata, wb_alu;
`ifdef MISALIGN_TRAP_EN
    logic        wb_misalign;
`endif

    mem_access_stage #(.WIDTH(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memtoreg(ex_memtoreg), .dmem_memwrite(dmem_memwrite), .dmem_addr(dmem_addr),
        .dmem_writedata(dmem_writedata), .dmem_readdata(dmem_readdata),
        .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
        .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd), .wb_rdata(wb_rdata), .wb_alu(wb_alu)
`ifdef MISALIGN_TRAP_EN
        , .wb_misalign(wb_misalign)
`endif
    );

    // Word-only data memory seen by the DUT
    logic [31:0] mem [0:63];
    assign dmem_readdata = mem[dmem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (dmem_memwrite) begin
            mem[dmem_addr[7:2]] <= dmem_writedata;
        end
    end

    // Reference model: byte-addressed memory plus expected writeback queue
    logic [7:0] ref_mem [0:255];
    typedef struct {
        logic [4:0]  rd;
        logic        regw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        ld;
        logic        mis;
    } exp_t;
    exp_t expq[$];
    exp_t cmp_e;

    int tests = 0, fails = 0, bubbles = 0;
    logic count_bub = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns);
        logic [7:0]  a;
        logic [15:0] h;
        a = addr[7:0];
        if (size == 2'b00) begin
            return uns ? {24'h0, ref_mem[a]} : {{24{ref_mem[a][7]}}, ref_mem[a]};
        end else if (size == 2'b01) begin
            a = {a[7:1], 1'b0};
            h = {ref_mem[a+1], ref_mem[a]};
            return uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return ref_word(a);
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] d);
        logic [7:0] a;
        a = addr[7:0];
        if (size == 2'b00) begin
            ref_mem[a] = d[7:0];
        end else if (size == 2'b01) begin
            a = {a[7:1], 1'b0};
            ref_mem[a] = d[7:0]; ref_mem[a+1] = d[15:8];
        end else begin
            a = {a[7:2], 2'b00};
            ref_mem[a] = d[7:0];   ref_mem[a+1] = d[15:8];
            ref_mem[a+2] = d[23:16]; ref_mem[a+3] = d[31:24];
        end
    endtask

    // Compare process: every valid MEM/WB slot against the expected queue
    always @(negedge clk) begin
        if (!reset) begin
            if (count_bub && !wb_valid) bubbles++;
            if (wb_valid) begin
                if (expq.size() == 0) begin
                    chk("wb_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    cmp_e = expq.pop_front();
                    chk("wb_rd", {27'h0, wb_rd}, {27'h0, cmp_e.rd});
                    chk("wb_regwrite", {31'h0, wb_regwrite}, {31'h0, cmp_e.regw});
                    chk("wb_memtoreg", {31'h0, wb_memtoreg}, {31'h0, cmp_e.m2r});
                    chk("wb_alu", wb_alu, cmp_e.alu);
                    if (cmp_e.ld) chk("wb_rdata", wb_rdata, cmp_e.rdata);
`ifdef MISALIGN_TRAP_EN
                    chk("wb_misalign", {31'h0, wb_misalign}, {31'h0, cmp_e.mis});
`endif
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that retires the instruction
    task automatic issue(input logic rd_en, input logic wr_en, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic regw, input logic m2r);
        exp_t e;
        logic st, ld, mis, s;
        logic [31:0] ww;
        int n;
        st  = wr_en;
        ld  = rd_en & ~wr_en;
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (st | ld) & (((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00)));
`endif
        e.rd = rd; e.regw = st ? 1'b0 : (regw & ~mis); e.m2r = m2r; e.alu = addr;
        e.ld = ld; e.mis = mis;
        e.rdata = ld ? model_load(addr, size, uns) : 32'h0;
        if (st && !mis) model_store(addr, size, wdata);
        ww = ref_word(addr[7:0]);
        ex_valid = 1'b1; ex_memread = rd_en; ex_memwrite = wr_en; ex_size = size;
        ex_unsigned = uns; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
        ex_regwrite = regw; ex_memtoreg = m2r;
        expq.push_back(e);
        @(negedge clk);
        chk("memwrite_first", {31'h0, dmem_memwrite}, {31'h0, st & ~mis & size[1]});
        if (st && !mis && size[1]) chk("word_wdata", dmem_writedata, wdata);
        n = 0;
        s = mem_stall;
        while (s && n < 4) begin
            n++;
            @(posedge clk); #1;
            @(negedge clk);
            chk("rmw_memwrite", {31'h0, dmem_memwrite}, 32'd1);
            chk("rmw_wdata", dmem_writedata, ww);
            s = mem_stall;
        end
        chk("stall_cycles", n, (st && !mis && !size[1]) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_memread = 1'b1; ex_memwrite = 1'b1; ex_regwrite = 1'b1;
        @(negedge clk);
        chk("idle_memwrite", {31'h0, dmem_memwrite}, 32'd0);
        chk("idle_stall", {31'h0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        chk("idle_wb_valid", {31'h0, wb_valid}, 32'd0);
        chk("idle_wb_regwrite", {31'h0, wb_regwrite}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
        reset = 1'b1; mem_clr = 1'b1;
        ex_valid = 0; ex_memread = 0; ex_memwrite = 0; ex_size = 0; ex_unsigned = 0;
        ex_addr = 0; ex_wdata = 0; ex_rd = 0; ex_regwrite = 0; ex_memtoreg = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'd0);
        chk("rst_wb_regwrite", {31'h0, wb_regwrite}, 32'd0);
        chk("rst_wb_rdata", wb_rdata, 32'd0);
        chk("rst_wb_alu", wb_alu, 32'd0);
        chk("rst_stall", {31'h0, mem_stall}, 32'd0);
        reset = 1'b0; mem_clr = 1'b0;

        // sw then lw
        issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0);
        chk("sw_word4", mem[4], 32'hDEADBEEF);
        issue(1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd3, 1, 1);
        chk("lw_rdata", wb_rdata, 32'hDEADBEEF);

        // sb read-modify-write
        issue(0, 1, 2'b10, 0, 32'h10, 32'h11223344, 5'd0, 0, 0);
        issue(0, 1, 2'b00, 0, 32'h12, 32'h000000AA, 5'd0, 0, 0);
        chk("sb_word4", mem[4], 32'h11AA3344);

        // sub-word load extension
        issue(0, 1, 2'b10, 0, 32'h10, 32'h8000FF7F, 5'd0, 0, 0);
        issue(1, 0, 2'b00, 0, 32'h10, 32'h0, 5'd4, 1, 1);
        chk("lb_10", wb_rdata, 32'h0000007F);
        issue(1, 0, 2'b00, 0, 32'h11, 32'h0, 5'd5, 1, 1);
        chk("lb_11", wb_rdata, 32'hFFFFFFFF);
        issue(1, 0, 2'b00, 1, 32'h11, 32'h0, 5'd6, 1, 1);
        chk("lbu_11", wb_rdata, 32'h000000FF);
        issue(1, 0, 2'b01, 0, 32'h12, 32'h0, 5'd7, 1, 1);
        chk("lh_12", wb_rdata, 32'hFFFF8000);
        issue(1, 0, 2'b01, 1, 32'h12, 32'h0, 5'd8, 1, 1);
        chk("lhu_12", wb_rdata, 32'h00008000);
        issue(1, 0, 2'b11, 0, 32'h10, 32'h0, 5'd9, 1, 1);
        chk("lw_size11", wb_rdata, 32'h8000FF7F);

        // non-memory passthrough and invalid slot
        issue(0, 0, 2'b10, 0, 32'h1234, 32'h0, 5'd7, 1, 0);
        chk("alu_pass", wb_alu, 32'h1234);
        idle();

        // reset during RMW abandons the store
        issue(0, 1, 2'b10, 0, 32'h14, 32'hFFFFFFFF, 5'd0, 0, 0);
        ex_valid = 1; ex_memread = 0; ex_memwrite = 1; ex_size = 2'b01; ex_unsigned = 0;
        ex_addr = 32'h16; ex_wdata = 32'h1234; ex_rd = 0; ex_regwrite = 0; ex_memtoreg = 0;
        @(negedge clk);
        chk("sh_stall", {31'h0, mem_stall}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_gate_memwrite", {31'h0, dmem_memwrite}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; ex_valid = 0; ex_memwrite = 0;
        chk("rmwrst_wb_valid", {31'h0, wb_valid}, 32'd0);
        chk("rmwrst_wb_rd", {27'h0, wb_rd}, 32'd0);
        chk("rmwrst_wb_alu", wb_alu, 32'd0);
        chk("rmwrst_wb_ctl", {30'h0, wb_regwrite, wb_memtoreg}, 32'd0);
        chk("rmwrst_word5", mem[5], 32'hFFFFFFFF);
        @(negedge clk);
        chk("rmwrst_idle_memwrite", {31'h0, dmem_memwrite}, 32'd0);
        chk("rmwrst_idle_stall", {31'h0, mem_stall}, 32'd0);
        @(posedge clk); #1;

        // back-to-back sb then sw: one bubble
        issue(0, 1, 2'b10, 0, 32'h20, 32'h0, 5'd0, 0, 0);
        issue(0, 1, 2'b10, 0, 32'h24, 32'h0, 5'd0, 0, 0);
        count_bub = 1'b1;
        issue(0, 1, 2'b00, 0, 32'h20, 32'h000000AA, 5'd0, 0, 0);
        issue(0, 1, 2'b10, 0, 32'h24, 32'hCAFEF00D, 5'd0, 0, 0);
        count_bub = 1'b0;
        chk("bubbles", bubbles, 32'd1);
        chk("b2b_word8", mem[8], 32'h000000AA);
        chk("b2b_word9", mem[9], 32'hCAFEF00D);

        // sh to odd address: trap, or land in the addr[1]-selected half
        issue(0, 1, 2'b01, 0, 32'h21, 32'h0000BEEF, 5'd0, 0, 0);
`ifdef MISALIGN_TRAP_EN
        chk("sh21_word8", mem[8], 32'h000000AA);
`else
        chk("sh21_word8", mem[8], 32'h0000BEEF);
`endif

        // load+store together: store wins
        issue(1, 1, 2'b10, 0, 32'h28, 32'h00000055, 5'd2, 0, 0);
        chk("ldst_word10", mem[10], 32'h00000055);
        idle();

        chk("queue_drained", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
